dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Responder (memory side) of the CPU data-memory request interface. Accepts one read/write
//   request at a time and inserts WAIT_CYCLES configurable wait states. Returns read data or
//   write completion via a valid/ready response channel. Replaces the zero-latency data memory
//   behind the CPU load/store path so that multi-cycle memory can be modelled.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words of storage
//   WAIT_CYCLES  2     wait states between request accept and response (0..15)
//   ADDR_W       32    request address width, byte address
// PORTS
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   req_valid   in   1       CPU presents a request
//   req_ready   out  1       responder can accept a request
//   req_we      in   1       1 = write, 0 = read
//   req_addr    in   ADDR_W  byte address; must be word aligned
//   req_wdata   in   32      write data
//   req_be      in   4       byte enables (present only with DMEM_BYTE_STROBE_EN)
//   resp_valid  out  1       response available
//   resp_ready  in   1       CPU takes the response
//   resp_rdata  out  32      read data (0 for writes and errors)
//   resp_err    out  1       misaligned or out-of-range access
// BEHAVIOUR
//   - One clock (clk). Reset is asynchronous and active-high on rst.
//   - FSM states: IDLE, WAIT, RESP. Reset -> IDLE.
//   - While rst is high: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
//   - req_ready = (state==IDLE) && !rst.
//   - Handshake and capture:
//     - A request is accepted on the clk edge where req_valid && req_ready.
//     - addr, we, wdata (and be) are captured on that edge. Inputs are ignored at all other times.
//   - IDLE -> WAIT on accept, with the wait counter loaded with WAIT_CYCLES-1.
//     - If WAIT_CYCLES==0: IDLE -> RESP directly.
//   - WAIT: the counter decrements each cycle. When the counter is 0: -> RESP.
//   - Commit point (the edge entering RESP):
//     - A write updates the array.
//     - A read samples the array into resp_rdata.
//     - resp_err is computed.
//   - Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
//   - RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_valid && resp_ready.
//     - On that edge: -> IDLE, and resp_valid/resp_rdata/resp_err are cleared.
//     - req_ready rises in the following cycle, so there is no same-cycle response+accept.
//   - Error: resp_err=1 if req_addr[1:0]!=0 or req_addr[ADDR_W-1:2] >= DEPTH_WORDS.
//     - No array write occurs; resp_rdata=0; latency is unchanged.
//   - Word index = req_addr[ADDR_W-1:2]. No wrap-around: out-of-range addresses are errors.
//   - Reset mid-operation aborts the transaction.
//     - A write not yet committed is not performed.
//     - Array contents are never cleared by reset.
//   - Array initial contents are undefined; the bench must write before it reads.
// CONFIGURATION
//   DMEM_BYTE_STROBE_EN defined:
//     - The req_be port exists.
//     - A write updates only the bytes whose req_be[i]=1 (byte i = bits 8i+7:8i).
//     - A write with req_be==4'b0000 completes with no change and resp_err=0.
//     - Reads ignore req_be and always return the full word.
//   DMEM_BYTE_STROBE_EN undefined:
//     - No req_be port.
//     - Every write updates the full word.
// STRUCTURE
//   dmem_defs.v (shared include):
//     - FSM state encodings DMEM_IDLE/DMEM_WAIT/DMEM_RESP (2 bits).
//     - DMEM_WORD_W=32.
//   dmem_array sub-module:
//     - Synchronous-write, registered-read word array.
//     - Ports: clk, we, be, idx, wdata, rdata.
//   dmem_responder:
//     - Holds the FSM, wait counter, request capture registers and the error check.
// TESTING
//   1. Reset: assert rst mid-cycle -> all outputs 0 immediately; release -> req_ready=1 next cycle.
//   2. Write then read, WAIT_CYCLES=2:
//      - Write 0xDEADBEEF @0x10 -> resp_valid 3 cycles after accept, err=0.
//      - Read @0x10 -> rdata=0xDEADBEEF.
//   3. Backpressure: hold resp_ready=0 for 5 cycles in RESP.
//      - resp_valid, rdata and err stay stable; req_ready=0 throughout.
//      - Release -> IDLE, then req_ready=1.
//   4. Errors:
//      - Read @0x13 -> err=1, rdata=0.
//      - Write @(DEPTH_WORDS*4) -> err=1, and a later read of word 0 is unchanged.
//   5. Reset during WAIT of a write of 0x12345678 @0x20 -> a later read @0x20 returns the prior value.
//   6. With DMEM_BYTE_STROBE_EN:
//      - Word 0x11223344 @0x0, then write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
//      - Also re-run case 2 with WAIT_CYCLES=0 -> latency is 1 cycle.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// word width, and the byte-enable merge used by the storage array.
// No ports; imported by dmem_array and dmem_responder.
package dmem_responder_pkg;

   localparam int DMEM_WORD_W = 32;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_t;

   // Replace only the bytes whose enable bit is set; the others keep old_w.
   function automatic logic [DMEM_WORD_W-1:0] dmem_merge(
      input logic [DMEM_WORD_W-1:0] old_w,
      input logic [DMEM_WORD_W-1:0] new_w,
      input logic [3:0]             be
   );
      logic [DMEM_WORD_W-1:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous byte-masked write, registered read.
// Latency: rdata reflects mem[idx] as it was before the same edge's write, one edge after idx.
// Backpressure: none; accepts a write on every edge where we=1. Contents are never reset.
// Ports: clk, we (write strobe), be (byte enables), idx (word index), wdata, rdata.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [3:0]             be,
   input  logic [IDX_W-1:0]       idx,
   input  logic [DMEM_WORD_W-1:0] wdata,
   output logic [DMEM_WORD_W-1:0] rdata
);

   logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= dmem_merge(mem[idx], wdata, be);
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data-memory request channel, one request in flight.
// Latency: resp_valid is seen WAIT_CYCLES+1 cycles after the accept edge.
// Backpressure: response held stable until resp_ready; req_ready low outside IDLE.
// Ports: clk, rst (async, active high), req_valid/req_ready/req_we/req_addr/req_wdata
//        [req_be when DMEM_BYTE_STROBE_EN is defined], resp_valid/resp_ready/resp_rdata/resp_err.
// Build option DMEM_BYTE_STROBE_EN: adds req_be and byte-masked writes; otherwise full-word writes.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DMEM_WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]             req_be,
`endif
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DMEM_WORD_W-1:0] resp_rdata,
   output logic                   resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_t            state, state_nxt;
   logic [3:0]             cnt;
   logic [ADDR_W-1:0]      addr_q;
   logic                   we_q;
   logic [DMEM_WORD_W-1:0] wdata_q;
   logic [3:0]             be_q;

   logic                   accept;
   logic                   commit;
   logic [ADDR_W-1:0]      src_addr;
   logic                   src_we;
   logic [DMEM_WORD_W-1:0] src_wdata;
   logic [3:0]             src_be;
   logic                   arr_we;
   logic [DMEM_WORD_W-1:0] arr_rdata;

   function automatic logic addr_err(input logic [ADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
   endfunction

   assign accept = req_valid && req_ready;

   // With zero wait states the commit edge is the accept edge, so the array
   // must see the live request; otherwise it sees the captured copy.
   assign commit = (state == DMEM_IDLE && accept && WAIT_CYCLES == 0) ||
                   (state == DMEM_WAIT && cnt == 4'd0);

   assign src_addr  = (state == DMEM_IDLE) ? req_addr  : addr_q;
   assign src_we    = (state == DMEM_IDLE) ? req_we    : we_q;
   assign src_wdata = (state == DMEM_IDLE) ? req_wdata : wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
   assign src_be    = (state == DMEM_IDLE) ? req_be    : be_q;
`else
   assign src_be    = 4'hF;
`endif

   assign arr_we = commit && src_we && !addr_err(src_addr);

   // State register, wait counter and request capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= DMEM_IDLE;
         cnt     <= 4'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= 4'h0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt     <= 4'(WAIT_CYCLES - 1);
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            be_q    <= src_be;
         end else if (state == DMEM_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         DMEM_IDLE: if (accept)     state_nxt = (WAIT_CYCLES == 0) ? DMEM_RESP : DMEM_WAIT;
         DMEM_WAIT: if (cnt == 4'd0) state_nxt = DMEM_RESP;
         DMEM_RESP: if (resp_ready) state_nxt = DMEM_IDLE;
         default:                   state_nxt = DMEM_IDLE;
      endcase
   end

   // Outputs. The array read register holds mem[addr_q] throughout RESP because
   // nothing writes the array outside the commit edge.
   always_comb begin
      req_ready  = (state == DMEM_IDLE) && !rst;
      resp_valid = (state == DMEM_RESP);
      resp_err   = (state == DMEM_RESP) && addr_err(addr_q);
      resp_rdata = '0;
      if (state == DMEM_RESP && !we_q && !addr_err(addr_q)) begin
         resp_rdata = arr_rdata;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (src_be),
      .idx   (src_addr[IDX_W+1:2]),
      .wdata (src_wdata),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2 instance plus a
// WAIT_CYCLES=0 instance). Inputs change and outputs are sampled on the falling edge.
module tb_dmem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_we, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid_z, req_we_z, resp_ready_z;
   logic [31:0] req_addr_z, req_wdata_z;
   logic        req_ready_z, resp_valid_z, resp_err_z;
   logic [31:0] resp_rdata_z;

`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]  req_be;
   logic [3:0]  req_be_z;
`endif

   int checks   = 0;
   int failures = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
      .req_be     (req_be),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .ADDR_W(32)) dut_z (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_z),
      .req_ready  (req_ready_z),
      .req_we     (req_we_z),
      .req_addr   (req_addr_z),
      .req_wdata  (req_wdata_z),
`ifdef DMEM_BYTE_STROBE_EN
      .req_be     (req_be_z),
`endif
      .resp_valid (resp_valid_z),
      .resp_ready (resp_ready_z),
      .resp_rdata (resp_rdata_z),
      .resp_err   (resp_err_z)
   );

   // Present a request at a falling edge, wait for acceptance, then drop req_valid.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      while (!req_ready && n < 20) begin
         @(posedge clk); @(negedge clk); n++;
      end
      if (!req_ready) begin
         checks++; failures++;
         $display("FAIL issue_timeout req_ready=%b required=1", req_ready);
      end
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Counts falling-edge samples after the accept edge until resp_valid is seen.
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      if (!resp_valid) begin
         checks++; failures++;
         $display("FAIL resp_timeout resp_valid=%b required=1", resp_valid);
      end
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rd, output logic er);
      issue(we, addr, wdata);
      wait_resp(lat);
      rd = resp_rdata;
      er = resp_err;
      take_resp();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++; if (req_ready !== 1'b0)  begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
      checks++; if (resp_err !== 1'b0)   begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL rel_req_ready got=%b exp=1", req_ready); end
      checks++; if (req_ready_z !== 1'b1) begin failures++; $display("FAIL rel_req_ready_z got=%b exp=1", req_ready_z); end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic er;
      xact(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
      checks++; if (lat !== 3)        begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      checks++; if (er !== 1'b0)      begin failures++; $display("FAIL wr_err got=%b exp=0", er); end
      checks++; if (rd !== 32'h0)     begin failures++; $display("FAIL wr_rdata got=%h exp=0", rd); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL wr_valid_clear got=%b exp=0", resp_valid); end
      checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL wr_ready_back got=%b exp=1", req_ready); end
      xact(1'b0, 32'h10, 32'h0, lat, rd, er);
      checks++; if (lat !== 3)            begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      checks++; if (rd !== 32'hDEADBEEF)  begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", rd); end
      checks++; if (er !== 1'b0)          begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] rd; logic er;
      xact(1'b1, 32'h4, 32'h0BADCAFE, lat, rd, er);
      issue(1'b0, 32'h4, 32'h0);
      wait_resp(lat);
      for (int c = 0; c < 5; c++) begin
         checks++; if (resp_valid !== 1'b1)  begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, resp_valid); end
         checks++; if (resp_rdata !== 32'h0BADCAFE) begin failures++; $display("FAIL bp_rdata[%0d] got=%h exp=0badcafe", c, resp_rdata); end
         checks++; if (resp_err !== 1'b0)    begin failures++; $display("FAIL bp_err[%0d] got=%b exp=0", c, resp_err); end
         checks++; if (req_ready !== 1'b0)   begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", c, req_ready); end
         @(posedge clk); @(negedge clk);
      end
      take_resp();
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL bp_release_rdata got=%h exp=0", resp_rdata); end
      checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL bp_release_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic er;
      xact(1'b0, 32'h13, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1)  begin failures++; $display("FAIL mis_err got=%b exp=1", er); end
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=0", rd); end
      checks++; if (lat !== 3)    begin failures++; $display("FAIL mis_latency got=%0d exp=3", lat); end
      xact(1'b1, 32'h0, 32'h55AA55AA, lat, rd, er);
      xact(1'b1, 32'd4096, 32'hFFFFFFFF, lat, rd, er);
      checks++; if (er !== 1'b1)  begin failures++; $display("FAIL oor_err got=%b exp=1", er); end
      checks++; if (lat !== 3)    begin failures++; $display("FAIL oor_latency got=%0d exp=3", lat); end
      xact(1'b0, 32'h0, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL oor_word0 got=%h exp=55aa55aa", rd); end
      xact(1'b1, 32'hFFC, 32'h01020304, lat, rd, er);
      checks++; if (er !== 1'b0)  begin failures++; $display("FAIL last_wr_err got=%b exp=0", er); end
      xact(1'b0, 32'hFFC, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL last_rd got=%h exp=01020304", rd); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic er;
      xact(1'b1, 32'h20, 32'hCAFEF00D, lat, rd, er);
      issue(1'b1, 32'h20, 32'h12345678);
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0)  begin failures++; $display("FAIL midwait_ready got=%b exp=0", req_ready); end
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xact(1'b0, 32'h20, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL aborted_write got=%h exp=cafef00d", rd); end
      issue(1'b0, 32'h10, 32'h0);
      wait_resp(lat);
      #2 rst = 1'b1;
      #1;
      checks++; if (resp_valid !== 1'b0)  begin failures++; $display("FAIL midresp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL midresp_rdata got=%h exp=0", resp_rdata); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL midresp_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] wr_data;
      for (int k = 0; k < 2; k++) begin
         wr_data = 32'hDEADBEEF;
         req_valid_z = 1'b1; req_we_z = (k == 0); req_addr_z = 32'h10; req_wdata_z = wr_data;
         checks++; if (req_ready_z !== 1'b1) begin failures++; $display("FAIL z_ready[%0d] got=%b exp=1", k, req_ready_z); end
         @(posedge clk); @(negedge clk);
         req_valid_z = 1'b0;
         checks++; if (resp_valid_z !== 1'b1) begin failures++; $display("FAIL z_latency[%0d] valid=%b exp=1", k, resp_valid_z); end
         checks++; if (resp_err_z !== 1'b0)   begin failures++; $display("FAIL z_err[%0d] got=%b exp=0", k, resp_err_z); end
         if (k == 1) begin
            checks++; if (resp_rdata_z !== 32'hDEADBEEF) begin failures++; $display("FAIL z_rdata got=%h exp=deadbeef", resp_rdata_z); end
         end
         resp_ready_z = 1'b1;
         @(posedge clk); @(negedge clk);
         resp_ready_z = 1'b0;
         checks++; if (resp_valid_z !== 1'b0) begin failures++; $display("FAIL z_clear[%0d] got=%b exp=0", k, resp_valid_z); end
      end
   endtask

`ifdef DMEM_BYTE_STROBE_EN
   task automatic test_strobe();
      int lat; logic [31:0] rd; logic er;
      req_be = 4'hF;
      xact(1'b1, 32'h0, 32'h11223344, lat, rd, er);
      req_be = 4'b0101;
      xact(1'b1, 32'h0, 32'hAABBCCDD, lat, rd, er);
      req_be = 4'b0000;
      xact(1'b0, 32'h0, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
      xact(1'b1, 32'h0, 32'hFFFFFFFF, lat, rd, er);
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL be_zero_err got=%b exp=0", er); end
      xact(1'b0, 32'h0, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be_zero_keep got=%h exp=11bb33dd", rd); end
      req_be = 4'hF;
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = 32'h0; req_wdata_z = 32'h0; resp_ready_z = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
      req_be = 4'hF;
      req_be_z = 4'hF;
`endif
      test_reset();
      test_write_read();
      test_backpressure();
      test_errors();
      test_reset_mid();
      test_zero_wait();
`ifdef DMEM_BYTE_STROBE_EN
      test_strobe();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
